// File: rtl/sprite_blitter_if.sv
// Signal bundle between the display FSM / sprite ROM side (master) and the
// sprite blitter (slave): blit request, ROM read port and VGA plot port.
interface sprite_blitter_if #(
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int COLOUR_BITS = 3,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7
);
  localparam int AW = $clog2(SPR_W * SPR_H);

  logic                   start;
  logic                   erase;
  logic [X_BITS-1:0]      pos_x;
  logic [Y_BITS-1:0]      pos_y;
  logic [COLOUR_BITS-1:0] bg_colour;
  logic [AW-1:0]          rom_addr;
  logic [COLOUR_BITS-1:0] rom_data;
  logic [X_BITS-1:0]      vga_x;
  logic [Y_BITS-1:0]      vga_y;
  logic [COLOUR_BITS-1:0] vga_colour;
  logic                   vga_plot;
  logic                   busy;
  logic                   done;

  // The master side also models the registered sprite ROM, so it owns rom_data.
  modport master (
    output start, erase, pos_x, pos_y, bg_colour, rom_data,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  start, erase, pos_x, pos_y, bg_colour, rom_data,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite renderer: scans a SPR_W x SPR_H sprite from a registered colour ROM and
// emits one clipped, transparency-masked pixel per cycle to the VGA plot port.
module sprite_blitter #(
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int COLOUR_BITS = 3,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int TRANSPARENT = 0
) (
  input  logic            clk,
  input  logic            reset,
  sprite_blitter_if.slave bus
);
  localparam int N  = SPR_W * SPR_H;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0]          LAST_ADDR = AW'(N - 1);
  localparam logic [CW-1:0]          LAST_COL  = CW'(SPR_W - 1);
  localparam logic [X_BITS:0]        LIMIT_X   = (X_BITS + 1)'(SCREEN_W);
  localparam logic [Y_BITS:0]        LIMIT_Y   = (Y_BITS + 1)'(SCREEN_H);
  localparam logic [COLOUR_BITS-1:0] CLEAR     = COLOUR_BITS'(TRANSPARENT);

  logic [1:0]             state;
  logic [AW-1:0]          addr;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;

  logic                   lat_erase;
  logic [X_BITS-1:0]      lat_x;
  logic [Y_BITS-1:0]      lat_y;
  logic [COLOUR_BITS-1:0] lat_bg;

  // Coordinates of the address whose ROM word is arriving this cycle.
  logic                   p_valid;
  logic [CW-1:0]          p_col;
  logic [RW-1:0]          p_row;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, matching real flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      col       <= '0;
      row       <= '0;
      lat_erase <= 1'b0;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_bg    <= '0;
      p_valid   <= 1'b0;
      p_col     <= '0;
      p_row     <= '0;
    end else begin
      p_valid <= (state == S_SCAN);
      p_col   <= col;
      p_row   <= row;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lat_erase <= bus.erase;
            lat_x     <= bus.pos_x;
            lat_y     <= bus.pos_y;
            lat_bg    <= bus.bg_colour;
            addr      <= '0;
            col       <= '0;
            row       <= '0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (addr == LAST_ADDR) begin
            state <= S_DRAIN;
          end else begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [X_BITS:0] sum_x;
  logic [Y_BITS:0] sum_y;
  logic            visible;

  // The pixel is formed in the same cycle the ROM word returns, so pixel p
  // appears two cycles after start and the last one lands in DRAIN.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum_x   = {1'b0, lat_x} + (X_BITS + 1)'(p_col);
    sum_y   = {1'b0, lat_y} + (Y_BITS + 1)'(p_row);
    visible = 1'b0;
    if (p_valid && (bus.rom_data != CLEAR) && (sum_x < LIMIT_X) && (sum_y < LIMIT_Y))
      visible = 1'b1;
  end

  assign bus.rom_addr   = addr;
  assign bus.vga_x      = p_valid ? sum_x[X_BITS-1:0] : '0;
  assign bus.vga_y      = p_valid ? sum_y[Y_BITS-1:0] : '0;
  assign bus.vga_colour = !p_valid ? '0 : (lat_erase ? lat_bg : bus.rom_data);
  assign bus.vga_plot   = visible;
  assign bus.busy       = (state == S_SCAN) || (state == S_DRAIN);
  assign bus.done       = (state == S_DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of directed blits, a reset
// mid-blit sequence and randomized blits against a per-pixel reference model.
module tb_sprite_blitter;
  localparam int SPR_W       = 8;
  localparam int SPR_H       = 8;
  localparam int COLOUR_BITS = 3;
  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 7;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int TRANSPARENT = 0;
  localparam int N           = SPR_W * SPR_H;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [COLOUR_BITS-1:0] rom [N];

  sprite_blitter_if #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .COLOUR_BITS(COLOUR_BITS),
    .X_BITS(X_BITS), .Y_BITS(Y_BITS)
  ) bus ();

  sprite_blitter #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .COLOUR_BITS(COLOUR_BITS),
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H), .TRANSPARENT(TRANSPARENT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Registered sprite ROM: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    int px;
    int py;
    bit er;
    int bg;
    int pat;       // 0: all 100, 1: checkerboard 0/010, 2: all 111
    bit hold;      // keep start high through the blit
    int chg;       // cycle at which the inputs are disturbed (0 = never)
    int new_x;
    int exp_plots;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input int pat);
    for (int p = 0; p < N; p++) begin
      case (pat)
        0:       rom[p] = 3'b100;
        1:       rom[p] = (((p / SPR_W) + (p % SPR_W)) % 2 == 1) ? 3'b010 : 3'b000;
        2:       rom[p] = 3'b111;
        default: rom[p] = COLOUR_BITS'($urandom_range(0, 7));
      endcase
    end
  endtask

  // Reference: what the screen should receive for sprite pixel p.
  function automatic void model_pixel(input int p, input int px, input int py,
                                      input bit er, input int bg,
                                      output bit plot, output int x, output int y,
                                      output int colour);
    int sx = px + (p % SPR_W);
    int sy = py + (p / SPR_W);
    plot   = (int'(rom[p]) != TRANSPARENT) && (sx < SCREEN_W) && (sy < SCREEN_H);
    x      = sx % (1 << X_BITS);
    y      = sy % (1 << Y_BITS);
    colour = er ? bg : int'(rom[p]);
  endfunction

  // Cycle 0 is the negedge-to-posedge window in which start is sampled;
  // every later sample is taken on the negedge inside cycle c.
  task automatic run_blit(input int vi, input int px, input int py, input bit er,
                          input int bg, input bit hold, input int chg,
                          input int new_x, output int plots);
    bit ep;
    int ex, ey, ec;
    plots = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.erase     = er;
    bus.pos_x     = X_BITS'(px);
    bus.pos_y     = Y_BITS'(py);
    bus.bg_colour = COLOUR_BITS'(bg);
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.start = 1'b0;
      if (c == chg) begin
        bus.pos_x     = X_BITS'(new_x);
        bus.pos_y     = Y_BITS'(py + 3);
        bus.erase     = ~er;
        bus.bg_colour = COLOUR_BITS'(~bg);
      end
      check($sformatf("v%0d c%0d busy", vi, c), 32'(bus.busy), 32'(c <= N + 1));
      check($sformatf("v%0d c%0d done", vi, c), 32'(bus.done), 32'(c == N + 2));
      ep = 1'b0; ex = 0; ey = 0; ec = 0;
      if (c >= 2 && c <= N + 1) model_pixel(c - 2, px, py, er, bg, ep, ex, ey, ec);
      check($sformatf("v%0d c%0d plot", vi, c), 32'(bus.vga_plot), 32'(ep));
      if (ep) begin
        check($sformatf("v%0d c%0d x", vi, c), 32'(bus.vga_x), ex);
        check($sformatf("v%0d c%0d y", vi, c), 32'(bus.vga_y), ey);
        check($sformatf("v%0d c%0d colour", vi, c), 32'(bus.vga_colour), ec);
      end
      if (bus.vga_plot === 1'b1) plots++;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   plots;
    int   exp_plots;
    int   stray_done;
    int   stray_plot;

    vectors     = 0;
    miscompares = 0;
    vecs[0] = '{px:10,  py:20,  er:0, bg:0, pat:0, hold:0, chg:0,  new_x:0,  exp_plots:64};
    vecs[1] = '{px:10,  py:20,  er:0, bg:0, pat:1, hold:0, chg:0,  new_x:0,  exp_plots:32};
    vecs[2] = '{px:156, py:116, er:0, bg:0, pat:2, hold:0, chg:0,  new_x:0,  exp_plots:16};
    vecs[3] = '{px:40,  py:40,  er:1, bg:1, pat:1, hold:0, chg:0,  new_x:0,  exp_plots:32};
    vecs[4] = '{px:10,  py:20,  er:0, bg:0, pat:0, hold:1, chg:10, new_x:90, exp_plots:64};
    vecs[5] = '{px:90,  py:20,  er:0, bg:0, pat:0, hold:0, chg:0,  new_x:0,  exp_plots:64};

    bus.start     = 1'b0;
    bus.erase     = 1'b0;
    bus.pos_x     = '0;
    bus.pos_y     = '0;
    bus.bg_colour = '0;
    fill_rom(0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy",     32'(bus.busy),       0);
    check("reset done",     32'(bus.done),       0);
    check("reset plot",     32'(bus.vga_plot),   0);
    check("reset rom_addr", 32'(bus.rom_addr),   0);
    check("reset vga_x",    32'(bus.vga_x),      0);
    check("reset vga_y",    32'(bus.vga_y),      0);
    check("reset colour",   32'(bus.vga_colour), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_rom(vecs[i].pat);
      run_blit(i, vecs[i].px, vecs[i].py, vecs[i].er, vecs[i].bg,
               vecs[i].hold, vecs[i].chg, vecs[i].new_x, plots);
      check($sformatf("v%0d plot count", i), plots, vecs[i].exp_plots);
    end

    // Reset while pixels are streaming out.
    fill_rom(0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.erase = 1'b0;
    bus.pos_x = 8'd10;
    bus.pos_y = 7'd20;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 30) reset = 1'b1;
    end
    @(negedge clk);
    check("midreset busy",     32'(bus.busy),     0);
    check("midreset plot",     32'(bus.vga_plot), 0);
    check("midreset done",     32'(bus.done),     0);
    check("midreset rom_addr", 32'(bus.rom_addr), 0);
    check("midreset vga_x",    32'(bus.vga_x),    0);
    reset      = 1'b0;
    stray_done = 0;
    stray_plot = 0;
    repeat (N + 10) begin
      @(negedge clk);
      if (bus.done !== 1'b0) stray_done++;
      if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0) stray_plot++;
    end
    check("midreset no done after", stray_done, 0);
    check("midreset idle after",    stray_plot, 0);
    run_blit(100, 10, 20, 1'b0, 0, 1'b0, 0, 0, plots);
    check("post-reset plot count", plots, 64);

    // Randomized blits, including disturbed inputs mid-blit.
    for (int r = 0; r < 20; r++) begin
      int px = int'($urandom_range(0, 255));
      int py = int'($urandom_range(0, 127));
      bit er = 1'(($urandom_range(0, 3)) == 0);
      int bg = int'($urandom_range(0, 7));
      int chg = int'($urandom_range(0, N + 1));
      fill_rom(3);
      exp_plots = 0;
      for (int p = 0; p < N; p++) begin
        bit ep;
        int ex, ey, ec;
        model_pixel(p, px, py, er, bg, ep, ex, ey, ec);
        if (ep) exp_plots++;
      end
      run_blit(200 + r, px, py, er, bg, 1'b0, chg, int'($urandom_range(0, 255)), plots);
      check($sformatf("rand%0d plot count", r), plots, exp_plots);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
